mem_access_ctrl: RTL and testbench

//  Initiator side of the data-memory port: MEM-stage load/store requests in, data-memory strobes out.

---
 rtl/mem_access_pkg.sv | 31 +++
 rtl/byte_lane_merge.sv | 22 ++
 rtl/mem_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM states and lane helpers for the data-memory controller.
// Build option SUBWORD_STORE_EN enables read-modify-write byte/half stores.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size
    );
        case (size)
            SZ_BYTE: return {24'b0, word[{off, 3'b000} +: 8]};
            SZ_HALF: return {16'b0, word[{off[1], 4'b0000} +: 16]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Replaces the addressed byte/half lane of a word with right-justified data.
// Used only when SUBWORD_STORE_EN is defined.
module byte_lane_merge
    import mem_access_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{off, 3'b000} +: 8]     = new_data[7:0];
            SZ_HALF: merged[{off[1], 4'b0000} +: 16] = new_data[15:0];
            default: merged = new_data;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: one request at a time, registered strobes.
// Define SUBWORD_STORE_EN to build byte/half stores as read-modify-write.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        stall_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_write_o,
    output logic        mem_read_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic [31:0]      wdata_q;
    logic [31:0]      word_idx;
    logic             acc_err;

    // Upper byte-address bits are dropped, so accesses wrap within memory.
    assign word_idx = {{(32-ADDR_W){1'b0}}, req_addr_i[ADDR_W+1:2]};

    always_comb begin
        acc_err = (req_size_i == SZ_RSVD)
               || (req_size_i == SZ_HALF && req_addr_i[0])
               || (req_size_i == SZ_WORD && req_addr_i[1:0] != 2'b00);
`ifndef SUBWORD_STORE_EN
        if (req_write_i && req_size_i != SZ_WORD)
            acc_err = 1'b1;
`endif
    end

`ifdef SUBWORD_STORE_EN
    logic [31:0] merged;

    byte_lane_merge u_merge (
        .old_word (mem_rdata_i),
        .new_data (wdata_q),
        .off      (off_q),
        .size     (size_q),
        .merged   (merged)
    );
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= '0;
            resp_err_o   <= 1'b0;
            stall_o      <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            mem_write_o  <= 1'b0;
            mem_read_o   <= 1'b0;
            cnt          <= '0;
            off_q        <= '0;
            size_q       <= SZ_BYTE;
            wdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        stall_o     <= 1'b1;
                        off_q       <= req_addr_i[1:0];
                        size_q      <= req_size_i;
                        wdata_q     <= req_wdata_i;
                        cnt         <= '0;
                        if (acc_err) begin
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                        end else begin
                            mem_addr_o <= word_idx;
                            if (!req_write_i) begin
                                state      <= READ;
                                mem_read_o <= 1'b1;
                            end else if (req_size_i == SZ_WORD) begin
                                state       <= WRITE;
                                mem_write_o <= 1'b1;
                                mem_wdata_o <= req_wdata_i;
                            end
`ifdef SUBWORD_STORE_EN
                            else begin
                                state      <= RMW_RD;
                                mem_read_o <= 1'b1;
                            end
`endif
                        end
                    end
                end
                READ: begin
                    if (cnt == CNT_LAST) begin
                        state        <= RESP;
                        mem_read_o   <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_rdata_o <= lane_extract(mem_rdata_i, off_q, size_q);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    state        <= RESP;
                    mem_write_o  <= 1'b0;
                    resp_valid_o <= 1'b1;
                end
`ifdef SUBWORD_STORE_EN
                RMW_RD: begin
                    if (cnt == CNT_LAST) begin
                        state       <= RMW_WR;
                        mem_read_o  <= 1'b0;
                        mem_write_o <= 1'b1;
                        mem_wdata_o <= merged;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RMW_WR: begin
                    state        <= RESP;
                    mem_write_o  <= 1'b0;
                    resp_valid_o <= 1'b1;
                end
`endif
                RESP: begin
                    state        <= IDLE;
                    resp_valid_o <= 1'b0;
                    resp_rdata_o <= '0;
                    resp_err_o   <= 1'b0;
                    stall_o      <= 1'b0;
                    req_ready_o  <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    mem_read_o  <= 1'b0;
                    mem_write_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with RD_LAT=2 and a small memory model.
// Sub-word store expectations follow SUBWORD_STORE_EN.
module tb_mem_access_ctrl;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic [31:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(8), .RD_LAT(2)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_size_i   (req_size),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .stall_o      (stall),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_write_o  (mem_write),
        .mem_read_o   (mem_read),
        .mem_rdata_i  (mem_rdata)
    );

    always @(posedge clk)
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

    assign mem_rdata = mem[mem_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, sz, a, 32'h0);
        cyc();
        check({tag, ".rd1"}, {31'b0, mem_read}, 32'd1);
        check({tag, ".addr"}, mem_addr, 32'd4);
        cyc();
        check({tag, ".rd2"}, {31'b0, mem_read}, 32'd1);
        check({tag, ".early"}, {31'b0, resp_valid}, 32'd0);
        cyc();
        check({tag, ".resp"}, {31'b0, resp_valid}, 32'd1);
        check({tag, ".rdata"}, resp_rdata, exp);
        check({tag, ".err"}, {31'b0, resp_err}, 32'd0);
        check({tag, ".rd_off"}, {31'b0, mem_read}, 32'd0);
        cyc();
        check({tag, ".idle"}, {31'b0, req_ready}, 32'd1);
    endtask

    task automatic do_err(input string tag, input logic w,
                          input logic [1:0] sz, input logic [31:0] a);
        issue(w, sz, a, 32'h0000_1234);
        cyc();
        check({tag, ".resp"}, {31'b0, resp_valid}, 32'd1);
        check({tag, ".err"}, {31'b0, resp_err}, 32'd1);
        check({tag, ".strobe"}, {30'b0, mem_read, mem_write}, 32'd0);
        check({tag, ".rdata"}, resp_rdata, 32'd0);
        cyc();
        check({tag, ".idle"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        cyc();
        check("rst.ready", {31'b0, req_ready}, 32'd1);
        check("rst.stall", {31'b0, stall}, 32'd0);
        check("rst.resp", {31'b0, resp_valid}, 32'd0);
        check("rst.strobe", {30'b0, mem_read, mem_write}, 32'd0);
        check("rst.addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        cyc();

        issue(1'b1, SZ_WORD, 32'h10, 32'hDEAD_BEEF);
        cyc();
        check("st.wr", {31'b0, mem_write}, 32'd1);
        check("st.rd", {31'b0, mem_read}, 32'd0);
        check("st.addr", mem_addr, 32'd4);
        check("st.wdata", mem_wdata, 32'hDEAD_BEEF);
        check("st.stall", {31'b0, stall}, 32'd1);
        check("st.early", {31'b0, resp_valid}, 32'd0);
        cyc();
        check("st.resp", {31'b0, resp_valid}, 32'd1);
        check("st.err", {31'b0, resp_err}, 32'd0);
        check("st.wr_off", {31'b0, mem_write}, 32'd0);
        check("st.ready", {31'b0, req_ready}, 32'd0);
        check("st.stall2", {31'b0, stall}, 32'd1);
        cyc();
        check("st.done", {31'b0, resp_valid}, 32'd0);
        check("st.ready2", {31'b0, req_ready}, 32'd1);
        check("st.stall3", {31'b0, stall}, 32'd0);

        do_load("ld_w", SZ_WORD, 32'h10, 32'hDEAD_BEEF);
        do_load("ld_b3", SZ_BYTE, 32'h13, 32'h0000_00DE);
        do_load("ld_b1", SZ_BYTE, 32'h11, 32'h0000_00BE);
        do_load("ld_h2", SZ_HALF, 32'h12, 32'h0000_DEAD);
        do_load("ld_wrap", SZ_WORD, 32'h410, 32'hDEAD_BEEF);

        do_err("err_w12", 1'b0, SZ_WORD, 32'h12);
        do_err("err_h13", 1'b0, SZ_HALF, 32'h13);
        do_err("err_sz3", 1'b0, SZ_RSVD, 32'h10);

`ifdef SUBWORD_STORE_EN
        issue(1'b1, SZ_HALF, 32'h12, 32'h0000_1234);
        cyc();
        check("rmw.rd1", {31'b0, mem_read}, 32'd1);
        cyc();
        check("rmw.rd2", {31'b0, mem_read}, 32'd1);
        cyc();
        check("rmw.wr", {31'b0, mem_write}, 32'd1);
        check("rmw.rd_off", {31'b0, mem_read}, 32'd0);
        check("rmw.wdata", mem_wdata, 32'h1234_BEEF);
        cyc();
        check("rmw.resp", {31'b0, resp_valid}, 32'd1);
        check("rmw.err", {31'b0, resp_err}, 32'd0);
        check("rmw.wr_off", {31'b0, mem_write}, 32'd0);
        cyc();
        do_load("rmw.back", SZ_WORD, 32'h10, 32'h1234_BEEF);
`else
        do_err("sub_st", 1'b1, SZ_HALF, 32'h12);
        do_load("sub.back", SZ_WORD, 32'h10, 32'hDEAD_BEEF);
`endif

        issue(1'b0, SZ_WORD, 32'h10, 32'h0);
        cyc();
        check("arst.rd", {31'b0, mem_read}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst.rd_off", {31'b0, mem_read}, 32'd0);
        check("arst.stall", {31'b0, stall}, 32'd0);
        check("arst.ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("arst.noresp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("arst.after", {31'b0, resp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
